puf_tune_ctrl: RTL and testbench
================================

Name: puf_tune_ctrl

Overview:
- Closed-loop tuning controller for the arbiter PUF delay-balance network. Generalises the fixed 16-cell top/bottom thermometer decoder to any N.
- Binary-searches the tune level by measuring the response ones-rate over sample windows, then locks to a balanced level.
- Sits between the PUF core (consumes resp_bit) and the tunable capacitor cells (drives top/bottom). BIST/host sequences it via start/done.

Parameters:
- N, 16, tuning cells per side; 2N tune levels, 0..2N-1
- K, $clog2(2*N), tune_level width
- WIN_LOG2, 8, window = 2^WIN_LOG2 valid responses
- TOL, 4, accepted |ones - 2^(WIN_LOG2-1)| for lock
- SETTLE_CYC, 8, clocks waited after each level change before counting

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, single-cycle pulse; begins auto-tune (ignored while busy)
- manual_en, in, 1, override; level taken from manual_level
- manual_level, in, K, override level, clamped to 2N-1
- resp_valid, in, 1, resp_bit qualifier
- resp_bit, in, 1, PUF response sample
- tune_level, out, K, currently applied level
- top, out, N, top-side thermometer code
- bottom, out, N, bottom-side thermometer code
- busy, out, 1, auto-tune in progress
- done, out, 1, auto-tune finished; sticky until next start, manual_en or reset
- locked, out, 1, done with balance achieved
- fail, out, 1, done with search exhausted

Behaviour:
- Mapping, all registered with one clock of latency from tune_level:
  - L >= N: top = 2^(L-N+1)-1, bottom = 0.
  - L < N: top = 0, bottom = 2^(N-L)-1.
  - Examples with N=16: L=31 -> top=FFFF; L=16 -> top=0001; L=15 -> bottom=0001; L=0 -> bottom=FFFF.
- Reset values: tune_level = N, top = 1, bottom = 0, busy/done/locked/fail = 0, FSM = IDLE, all counters 0.
- FSM: IDLE -> SETTLE -> COUNT -> EVAL -> (SETTLE | DONE) -> IDLE.
- IDLE, on start: lo = 0, hi = 2N-1, busy = 1, done/locked/fail cleared. Next: SETTLE.
- SETTLE: tune_level = (lo+hi)>>1. Wait SETTLE_CYC clocks. resp ignored.
- COUNT: each resp_valid increments sample count and adds resp_bit to the ones count. Leave after exactly 2^WIN_LOG2 valid samples; gaps in resp_valid do not advance the window.
- EVAL: let d = ones - 2^(WIN_LOG2-1).
  - |d| <= TOL: locked = 1 -> DONE.
  - d > TOL: lo = mid+1.
  - d < -TOL: hi = mid-1.
  - Track best = mid with the strictly smallest |d|; the first evaluation always sets best.
  - If lo > hi: tune_level = best, fail = 1 -> DONE. lo/hi are K+1 bits so lo can reach 2N.
  - Otherwise -> SETTLE.
- DONE: busy = 0, done = 1. Next cycle -> IDLE, flags held.
- manual_en = 1 has priority:
  - FSM forced to IDLE; busy/done/locked/fail cleared.
  - tune_level = min(manual_level, 2N-1) every cycle.
  - start ignored.
  - On release, level is held.
- start while busy: ignored. Simultaneous start and manual_en: manual wins.
- Maximum windows per search: K+1.

Optional Feature:
- Macro PUF_TUNE_STATS_EN.
- Defined: adds output ports last_ones [WIN_LOG2:0] (ones count of the latest completed window, reset 0) and iter_cnt [3:0] (windows evaluated in the current/last search, cleared on start; saturating).
- Undefined: ports and their registers are absent; behaviour is otherwise identical.

Decomposition:
- Package puf_tune_pkg: FSM state enum (IDLE, SETTLE, COUNT, EVAL, DONE) and a thermometer-mapping function parametrised by N.
- One sub-module, puf_therm_dec: purely combinational level -> top/bottom mapping, parametrised N/K. The controller registers its outputs.

Test Plan (N=16, WIN_LOG2=4, TOL=1, SETTLE_CYC=2 unless noted):
- Reset release -> tune_level=16, top=0001, bottom=0000, busy=done=0.
- manual_en=1 with manual_level 0, 31, 22 -> after 2 clocks: bottom=FFFF; top=FFFF; top=007F (other side 0 in each case).
- PUF model: all-ones for level<20, all-zeros for level>20, alternating at 20; pulse start -> windows at 15, 23, 19, 21, 20; then locked=1, done=1, tune_level=20, top=001F.
- Constant all-ones stream, start -> mids 15, 23, 27, 29, 30, 31; then fail=1, locked=0, tune_level=15 (best: ties keep the first).
- resp_valid asserted only every 3rd cycle -> window ends exactly at the 16th valid sample; a start pulse during COUNT is ignored.
- rst_n low mid-COUNT, and manual_en raised mid-COUNT -> reset values restored asynchronously; manual case returns to IDLE with flags cleared.

Source files
------------

// File: rtl/puf_tune_pkg.sv
// puf_tune_pkg: shared types and helpers for the PUF delay-balance tuner.
// Holds the FSM state encoding and the level -> thermometer cell mapping.
package puf_tune_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        EVAL,
        DONE
    } tune_state_e;

    // Top-side cell i is on once the level reaches n+i.
    function automatic logic therm_top_bit(input int n, input int lvl, input int i);
        return (lvl >= n) && (i <= lvl - n);
    endfunction

    // Bottom-side cell i is on while the level is at or below n-1-i.
    function automatic logic therm_bot_bit(input int n, input int lvl, input int i);
        return (lvl < n) && (i < n - lvl);
    endfunction

endpackage

// File: rtl/puf_therm_dec.sv
// puf_therm_dec: combinational tune level -> top/bottom thermometer mapping.
// Level N lights one top cell; level N-1 lights one bottom cell.
module puf_therm_dec
    import puf_tune_pkg::*;
#(
    parameter int N = 16,
    parameter int K = $clog2(2*N)
) (
    input  logic [K-1:0] level,
    output logic [N-1:0] top,
    output logic [N-1:0] bottom
);

    // Every cell is an independent compare against the level.
    always_comb begin
        top    = '0;
        bottom = '0;
        for (int i = 0; i < N; i++) begin
            top[i]    = therm_top_bit(N, int'(level), i);
            bottom[i] = therm_bot_bit(N, int'(level), i);
        end
    end

endmodule

// File: rtl/puf_tune_ctrl.sv
// puf_tune_ctrl: closed-loop binary-search tuner for the arbiter PUF balance cells.
// Define PUF_TUNE_STATS_EN to add the last_ones / iter_cnt debug outputs.
module puf_tune_ctrl
    import puf_tune_pkg::*;
#(
    parameter int N          = 16,
    parameter int K          = $clog2(2*N),
    parameter int WIN_LOG2   = 8,
    parameter int TOL        = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              manual_en,
    input  logic [K-1:0]      manual_level,
    input  logic              resp_valid,
    input  logic              resp_bit,
    output logic [K-1:0]      tune_level,
    output logic [N-1:0]      top,
    output logic [N-1:0]      bottom,
    output logic              busy,
    output logic              done,
    output logic              locked,
    output logic              fail
`ifdef PUF_TUNE_STATS_EN
    ,
    output logic [WIN_LOG2:0] last_ones,
    output logic [3:0]        iter_cnt
`endif
);

    localparam int LVL_MAX = 2*N - 1;
    localparam int HALF    = 2**(WIN_LOG2-1);
    localparam int OW      = WIN_LOG2 + 1;
    localparam int KW      = K + 1;
    localparam int SW      = $clog2(SETTLE_CYC + 1);

    localparam logic [KW-1:0]       HI_INIT   = KW'(LVL_MAX);
    localparam logic [OW-1:0]       HALF_W    = OW'(HALF);
    localparam logic [SW-1:0]       SET_LAST  = SW'(SETTLE_CYC - 1);
    localparam logic [WIN_LOG2-1:0] SAMP_LAST = '1;

    tune_state_e state, state_nx;

    logic [KW-1:0]       lo, hi;
    logic [K-1:0]        mid, best, best_nx, lvl_clamp;
    logic [OW-1:0]       ones, abs_d, best_abs, best_abs_nx;
    logic [WIN_LOG2-1:0] samp;
    logic [SW-1:0]       settle_cnt;
    logic                best_vld, better;
    logic                settle_end, win_end;
    logic                go_up, go_dn, lock_hit, exhaust;
    logic                search_go, settle_on, count_on, eval_on;
    logic [N-1:0]        top_d, bot_d;

    puf_therm_dec #(.N(N), .K(K)) u_dec (
        .level  (tune_level),
        .top    (top_d),
        .bottom (bot_d)
    );

    // Window verdict, search direction and best-so-far candidate.
    always_comb begin
        mid         = K'((lo + hi) >> 1);
        abs_d       = (int'(ones) >= HALF) ? (ones - HALF_W) : (HALF_W - ones);
        go_up       = int'(ones) > HALF + TOL;
        go_dn       = int'(ones) < HALF - TOL;
        lock_hit    = !go_up && !go_dn;
        exhaust     = (go_up && ({1'b0, mid} == hi)) ||
                      (go_dn && ({1'b0, mid} == lo));
        better      = !best_vld || (abs_d < best_abs);
        best_nx     = better ? mid : best;
        best_abs_nx = better ? abs_d : best_abs;
        settle_end  = (settle_cnt == SET_LAST);
        win_end     = resp_valid && (samp == SAMP_LAST);
        lvl_clamp   = (int'(manual_level) > LVL_MAX) ? K'(LVL_MAX) : manual_level;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; manual override always parks the FSM in IDLE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SETTLE;
            SETTLE:  if (settle_end) state_nx = COUNT;
            COUNT:   if (win_end) state_nx = EVAL;
            EVAL:    state_nx = (lock_hit || exhaust) ? DONE : SETTLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (manual_en) state_nx = IDLE;
    end

    // Per-state datapath strobes.
    always_comb begin
        search_go = 1'b0;
        settle_on = 1'b0;
        count_on  = 1'b0;
        eval_on   = 1'b0;
        if (!manual_en) begin
            unique case (state)
                IDLE:    search_go = start;
                SETTLE:  settle_on = 1'b1;
                COUNT:   count_on  = 1'b1;
                EVAL:    eval_on   = 1'b1;
                DONE:    ;
                default: ;
            endcase
        end
    end

    // Search bounds, window counters, best level and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tune_level <= K'(N);
            lo         <= '0;
            hi         <= '0;
            best       <= '0;
            best_abs   <= '0;
            best_vld   <= 1'b0;
            ones       <= '0;
            samp       <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else if (manual_en) begin
            tune_level <= lvl_clamp;
            ones       <= '0;
            samp       <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            if (search_go) begin
                lo       <= '0;
                hi       <= HI_INIT;
                best_vld <= 1'b0;
                busy     <= 1'b1;
                done     <= 1'b0;
                locked   <= 1'b0;
                fail     <= 1'b0;
            end
            if (settle_on) begin
                tune_level <= mid;
                settle_cnt <= settle_end ? '0 : settle_cnt + 1'b1;
                samp       <= '0;
                ones       <= '0;
            end
            if (count_on && resp_valid) begin
                samp <= samp + 1'b1;
                ones <= ones + OW'(resp_bit);
            end
            if (eval_on) begin
                best     <= best_nx;
                best_abs <= best_abs_nx;
                best_vld <= 1'b1;
                if (go_up) lo <= {1'b0, mid} + 1'b1;
                if (go_dn) hi <= {1'b0, mid} - 1'b1;
                if (lock_hit) begin
                    locked <= 1'b1;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end else if (exhaust) begin
                    tune_level <= best_nx;
                    fail       <= 1'b1;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                end
            end
        end
    end

    // Registered thermometer drive, one clock behind tune_level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top    <= N'(1);
            bottom <= '0;
        end else begin
            top    <= top_d;
            bottom <= bot_d;
        end
    end

`ifdef PUF_TUNE_STATS_EN
    // Debug counters: latest window ones and windows spent in this search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ones <= '0;
            iter_cnt  <= '0;
        end else begin
            if (search_go) iter_cnt <= '0;
            if (eval_on) begin
                last_ones <= ones;
                if (iter_cnt != 4'hF) iter_cnt <= iter_cnt + 4'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_puf_tune_ctrl.sv
// tb_puf_tune_ctrl: closed-loop bench for puf_tune_ctrl with a per-level PUF model.
// Expected search paths come from a plain integer binary-search model.
module tb_puf_tune_ctrl;

    localparam int N    = 16;
    localparam int K    = 5;
    localparam int W    = 4;
    localparam int TOL  = 1;
    localparam int SC   = 2;
    localparam int HALF = 8;
    localparam int LMAX = 31;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         manual_en = 1'b0;
    logic [K-1:0] manual_level = '0;
    logic         resp_valid = 1'b0;
    logic         resp_bit = 1'b0;
    logic [K-1:0] tune_level;
    logic [N-1:0] top, bottom;
    logic         busy, done, locked, fail;
`ifdef PUF_TUNE_STATS_EN
    logic [W:0]   last_ones;
    logic [3:0]   iter_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int tab[32];
    int exp_mids[$];
    bit exp_lock;
    int exp_level;

    always #5 clk = ~clk;

    puf_tune_ctrl #(
        .N(N), .K(K), .WIN_LOG2(W), .TOL(TOL), .SETTLE_CYC(SC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .manual_en    (manual_en),
        .manual_level (manual_level),
        .resp_valid   (resp_valid),
        .resp_bit     (resp_bit),
        .tune_level   (tune_level),
        .top          (top),
        .bottom       (bottom),
        .busy         (busy),
        .done         (done),
        .locked       (locked),
        .fail         (fail)
`ifdef PUF_TUNE_STATS_EN
        ,
        .last_ones    (last_ones),
        .iter_cnt     (iter_cnt)
`endif
    );

    function automatic logic [15:0] exp_top(input int l);
        return (l >= N) ? 16'((1 << (l - N + 1)) - 1) : 16'h0;
    endfunction

    function automatic logic [15:0] exp_bot(input int l);
        return (l < N) ? 16'((1 << (N - l)) - 1) : 16'h0;
    endfunction

    // Reference search: integer bounds, ones count per level from tab[].
    task automatic model_search();
        int lo, hi, mid, d, a, best, best_a;
        lo = 0; hi = LMAX; best = 0; best_a = 1000;
        exp_mids.delete();
        for (int it = 0; it < 64; it++) begin
            mid = (lo + hi) / 2;
            exp_mids.push_back(mid);
            d = tab[mid] - HALF;
            a = (d < 0) ? -d : d;
            if (a < best_a) begin best = mid; best_a = a; end
            if (a <= TOL) begin exp_lock = 1; exp_level = mid; break; end
            if (d > 0) lo = mid + 1;
            else       hi = mid - 1;
            if (lo > hi) begin exp_lock = 0; exp_level = best; break; end
        end
    endtask

    // Hold a known level so the first search midpoint shows up as a change.
    task automatic park(input int lvl);
        @(negedge clk);
        manual_en = 1'b1;
        manual_level = K'(lvl);
        repeat (2) @(negedge clk);
        manual_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tune_level !== 5'd16 || top !== 16'h0001 || bottom !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_level: level=%0d top=%h bot=%h want 16/0001/0000",
                     tune_level, top, bottom);
        end
        n_cmp++;
        if ({busy, done, locked, fail} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, locked, fail});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tune_level !== 5'd16 || top !== 16'h0001 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: level=%0d top=%h busy=%b", tune_level, top, busy);
        end
    endtask

    task automatic test_manual();
        int lv[6];
        lv[0] = 0; lv[1] = 31; lv[2] = 22;
        for (int i = 3; i < 6; i++) lv[i] = $urandom_range(LMAX);
        for (int i = 0; i < 6; i++) begin
            manual_en = 1'b1;
            manual_level = K'(lv[i]);
            repeat (2) @(negedge clk);
            n_cmp++;
            if (top !== exp_top(lv[i]) || bottom !== exp_bot(lv[i]) ||
                tune_level !== K'(lv[i])) begin
                n_bad++;
                $display("FAIL manual_%0d: level=%0d top=%h bot=%h want %0d/%h/%h", lv[i],
                         tune_level, top, bottom, lv[i], exp_top(lv[i]), exp_bot(lv[i]));
            end
        end
        manual_en = 1'b0;
        @(negedge clk);
    endtask

    // Closed-loop search; any 16 consecutive valid samples at level L carry tab[L] ones.
    task automatic run_search(input string name, input int pct);
        int seen[$];
        int prev, gidx;
        bit got;
        park(0);
        model_search();
        prev = 0; gidx = 0; got = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (busy && int'(tune_level) != prev) begin
                seen.push_back(int'(tune_level));
                prev = int'(tune_level);
            end
            if (done) begin got = 1; break; end
            start = (cyc == 0);
            resp_valid = ($urandom_range(99) < pct);
            if (resp_valid) begin
                resp_bit = ((gidx % 16) < tab[tune_level]);
                gidx++;
            end else begin
                resp_bit = 1'($urandom_range(1));
            end
            @(negedge clk);
        end
        start = 1'b0;
        resp_valid = 1'b0;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s_timeout: done=%b want 1", name, done);
        end
        n_cmp++;
        if (seen.size() != exp_mids.size()) begin
            n_bad++;
            $display("FAIL %s_windows: got %0d want %0d", name, seen.size(), exp_mids.size());
        end
        for (int i = 0; i < seen.size() && i < exp_mids.size(); i++) begin
            n_cmp++;
            if (seen[i] != exp_mids[i]) begin
                n_bad++;
                $display("FAIL %s_mid%0d: got %0d want %0d", name, i, seen[i], exp_mids[i]);
            end
        end
        n_cmp++;
        if (locked !== exp_lock || fail !== !exp_lock || busy !== 1'b0 ||
            tune_level !== K'(exp_level)) begin
            n_bad++;
            $display("FAIL %s_result: lock=%b fail=%b busy=%b level=%0d want %b/%b/0/%0d",
                     name, locked, fail, busy, tune_level, exp_lock, !exp_lock, exp_level);
        end
`ifdef PUF_TUNE_STATS_EN
        n_cmp++;
        if (int'(iter_cnt) != exp_mids.size()) begin
            n_bad++;
            $display("FAIL %s_iter: got %0d want %0d", name, iter_cnt, exp_mids.size());
        end
`endif
        repeat (3) @(negedge clk);
        n_cmp++;
        if (top !== exp_top(exp_level) || bottom !== exp_bot(exp_level) || done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_drive: top=%h bot=%h done=%b want %h/%h/1", name, top, bottom,
                     done, exp_top(exp_level), exp_bot(exp_level));
        end
    endtask

    task automatic test_lock_20();
        for (int l = 0; l < 32; l++) tab[l] = (l < 20) ? 16 : (l > 20) ? 0 : 8;
        run_search("lock20", 100);
    endtask

    task automatic test_fail_ones();
        for (int l = 0; l < 32; l++) tab[l] = 16;
        run_search("allones", 100);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int t, v;
            t = $urandom_range(LMAX);
            for (int l = 0; l < 32; l++) begin
                if (r < 5) begin
                    v = HALF + (t - l) * 2 + $urandom_range(2) - 1;
                    tab[l] = (v < 0) ? 0 : (v > 16) ? 16 : v;
                end else begin
                    tab[l] = $urandom_range(16);
                end
            end
            run_search($sformatf("rand%0d", r), $urandom_range(30, 100));
        end
    endtask

    // Valid only every 3rd cycle; settle-time samples and a mid-window start must be ignored.
    task automatic test_sparse_valid();
        int vcyc[$];
        int cnt, d, used;
        bit got;
        park(0);
        cnt = 0; got = 0; d = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done) begin got = 1; d = cyc; break; end
            start = (cyc == 0) || (cyc == 12);
            resp_valid = 1'b0;
            resp_bit = 1'b0;
            if (cyc == 1 || cyc == 2) begin
                resp_valid = 1'b1;
                resp_bit = 1'b1;
            end else if (cyc >= 3 && cyc % 3 == 0) begin
                resp_valid = 1'b1;
                resp_bit = (cnt % 2 == 0);
                cnt++;
                vcyc.push_back(cyc);
            end
            @(negedge clk);
        end
        start = 1'b0;
        resp_valid = 1'b0;
        used = 0;
        foreach (vcyc[i]) if (vcyc[i] <= d - 2) used++;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL sparse_timeout: done=%b want 1", done);
        end
        n_cmp++;
        if (used != 16) begin
            n_bad++;
            $display("FAIL sparse_window: window closed after %0d samples want 16", used);
        end
        n_cmp++;
        if (locked !== 1'b1 || tune_level !== 5'd15) begin
            n_bad++;
            $display("FAIL sparse_lock: lock=%b level=%0d want 1/15", locked, tune_level);
        end
        @(negedge clk);
        n_cmp++;
        if (bottom !== 16'h0001 || top !== 16'h0) begin
            n_bad++;
            $display("FAIL sparse_drive: top=%h bot=%h want 0000/0001", top, bottom);
        end
    endtask

    // Start a search and feed it until it is well inside its first window.
    task automatic begin_search();
        for (int l = 0; l < 32; l++) tab[l] = 16;
        park(0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            start = (cyc == 0);
            resp_valid = 1'b1;
            resp_bit = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        resp_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        begin_search();
        n_cmp++;
        if (busy !== 1'b1 || bottom !== 16'h0001) begin
            n_bad++;
            $display("FAIL areset_pre: busy=%b bot=%h want 1/0001", busy, bottom);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tune_level !== 5'd16 || top !== 16'h0001 || bottom !== 16'h0 ||
            {busy, done, locked, fail} !== 4'b0) begin
            n_bad++;
            $display("FAIL areset_async: level=%0d top=%h bot=%h flags=%b want 16/0001/0000/0000",
                     tune_level, top, bottom, {busy, done, locked, fail});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || tune_level !== 5'd16) begin
            n_bad++;
            $display("FAIL areset_idle: busy=%b level=%0d want 0/16", busy, tune_level);
        end
    endtask

    task automatic test_manual_mid();
        int lv;
        lv = $urandom_range(1, LMAX);
        begin_search();
        manual_en = 1'b1;
        manual_level = K'(lv);
        start = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, locked, fail} !== 4'b0 || tune_level !== K'(lv) ||
            top !== exp_top(lv) || bottom !== exp_bot(lv)) begin
            n_bad++;
            $display("FAIL manmid_force: flags=%b level=%0d top=%h bot=%h want 0000/%0d/%h/%h",
                     {busy, done, locked, fail}, tune_level, top, bottom, lv,
                     exp_top(lv), exp_bot(lv));
        end
        manual_en = 1'b0;
        start = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b0 || tune_level !== K'(lv)) begin
            n_bad++;
            $display("FAIL manmid_release: busy=%b done=%b level=%0d want 0/0/%0d",
                     busy, done, tune_level, lv);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_lock_20();
        test_fail_ones();
        test_sparse_valid();
        test_random();
        test_async_reset();
        test_manual_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
